pushbutton_conditioner: RTL and testbench
=========================================

// Module: pushbutton_conditioner
// PURPOSE
//  Conditions raw board push-buttons before they reach the Qsys system's pushbutton_export PIO input.
//  - Synchronises the raw active-low keys to the system clock.
//  - Debounces each key.
//  - Drives the debounced level to pushbutton_export.
//  - Emits per-key press/release pulses and a valid/ready event stream for consumers outside the PIO.
// PARAMETERS
//  NUM_BUTTONS      4       number of keys (>=1)
//  DEBOUNCE_CYCLES  500000  consecutive differing samples needed to commit a change (10 ms @ 50 MHz; >=1)
//  IDX_W            derived localparam, max(1,$clog2(NUM_BUTTONS))
// PORTS
//  clk_clk            in   1            system clock (same domain as system_ref_clk_clk)
//  reset_reset_n      in   1            asynchronous, active-low reset
//  key_n_in           in   NUM_BUTTONS  raw pins, asynchronous, 0 = pressed
//  pushbutton_export  out  NUM_BUTTONS  debounced level, pin polarity kept (1 = released)
//  press_pulse        out  NUM_BUTTONS  1-cycle strobe when the debounced key goes 1->0
//  release_pulse      out  NUM_BUTTONS  1-cycle strobe when the debounced key goes 0->1
//  event_valid        out  1            event_data holds an unconsumed event
//  event_ready        in   1            consumer accepts the event when valid&ready
//  event_data         out  1+IDX_W      {is_release, key_index}
//  overflow           out  1            sticky: an event was lost
//  overflow_clr       in   1            synchronous clear of overflow
// BEHAVIOUR
//  Reset (async assert, sync deassert in the system):
//   - sync flops, stable and pushbutton_export all 1; counters 0.
//   - press/release pulses 0; pending bits 0; event_valid 0; event_data 0; overflow 0.
//  Synchroniser: 2 flops per key; sync output = key_n_in delayed 2 cycles.
//  Debounce, per key:
//   - sync == stable: counter <= 0.
//   - sync != stable and counter < DEBOUNCE_CYCLES-1: counter++.
//   - sync != stable and counter == DEBOUNCE_CYCLES-1: stable <= sync, counter <= 0 (commit).
//   - Any return to the stable level before commit restarts the count, so bounces are filtered.
//   - Latency: pin edge -> pushbutton_export change = DEBOUNCE_CYCLES+2 clocks for a clean edge.
//   - A level held for DEBOUNCE_CYCLES cycles commits; one held for DEBOUNCE_CYCLES-1 is dropped.
//  Pulses:
//   - Registered and asserted in the same cycle pushbutton_export changes.
//   - Never both high for one key; independent across keys.
//  Event path:
//   - On commit, set pend_press[i] (1->0) or pend_release[i] (0->1).
//   - Output register loads when !event_valid or (event_valid & event_ready).
//   - Load selects the lowest key index first, and press before release within a key.
//   - The loaded pending bit clears in the same cycle.
//   - No pending bits at load time: event_valid <= 0.
//   - Full throughput: one event per cycle while ready=1.
//   - event_data is stable while valid & !ready (no retraction, no change).
//  Overflow:
//   - A commit that hits an already-set pending bit sets overflow; the pending bit stays 1 (events merge).
//   - Set and pop of the same bit in one cycle: the pop consumes the old event, the bit stays set, no overflow.
//   - overflow_clr and a new overflow in one cycle: overflow stays 1.
//  Reset mid-debounce or with events pending: all state is discarded; no pulse or event is produced afterwards for the discarded activity.
// STRUCTURE
//  pushbutton_pkg (shared package or header):
//   - DEFAULT_DEBOUNCE_CYCLES.
//   - Event field positions: EV_IS_RELEASE bit = IDX_W; key index [IDX_W-1:0].
//  Sub-module button_debounce_channel, one per key via generate:
//   - Inputs: clk, reset_n, key_n.
//   - Outputs: level, press_pulse, release_pulse.
//   - Contains the synchroniser, counter and stable register.
//  Top level holds the pending vectors, the priority picker, the output register and the overflow logic.
// TESTING (bench uses DEBOUNCE_CYCLES=8, NUM_BUTTONS=4)
//  1. Reset: hold reset_reset_n=0 with key_n_in=4'b0000 -> pushbutton_export=4'hF, pulses 0, event_valid=0, overflow=0.
//  2. Clean press: key_n_in[2] 1->0 and held, event_ready=1 -> pushbutton_export[2]=0 exactly 10 clocks later.
//     Same cycle: press_pulse[2]=1 for 1 cycle. Next cycle: event_valid=1, event_data=3'b0_10.
//  3. Bounce: toggle key_n_in[1] every 3 clocks for 30 clocks, then hold 0 -> exactly one press event.
//     pushbutton_export[1] falls 10 clocks after the final edge.
//  4. Glitch boundary: key_n_in[0] low for 7 clocks -> no change, no event.
//     Low for 8 clocks -> a press commits, then a release commits 8 clocks later.
//  5. Arbitration: keys 0 and 3 pressed in the same cycle, event_ready=0 -> event_data=3'b0_00 held stable.
//     Raise ready -> key 0 event accepted, then 3'b0_11 on the next cycle, then event_valid=0.
//  6. Overflow/reset: ready=0, key 1 pressed/released twice -> overflow=1.
//     overflow_clr -> overflow=0. Assert reset 4 clocks into a debounce -> no pulse or event after release of reset.

Source files
------------

// File: rtl/pushbutton_pkg.sv
// rtl/pushbutton_pkg.sv - shared constants and helpers for the pushbutton conditioner
package pushbutton_pkg;

  localparam int DEFAULT_NUM_BUTTONS     = 4;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

  function automatic int idx_width(input int num_buttons);
    return (num_buttons > 1) ? $clog2(num_buttons) : 1;
  endfunction

  // Event word layout: {is_release, key_index}; the flag sits just above the index.
  function automatic int ev_is_release_bit(input int idx_w);
    return idx_w;
  endfunction

endpackage

// File: rtl/button_debounce_channel.sv
// rtl/button_debounce_channel.sv - per-key synchroniser, debounce counter and edge pulses
module button_debounce_channel
  import pushbutton_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int              CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  always_comb begin
    sync1_d   = key_n;
    sync2_d   = sync1_q;
    stable_d  = stable_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      // Enough consecutive differing samples: commit and strobe the matching edge.
      stable_d  = sync2_q;
      cnt_d     = '0;
      press_d   = ~sync2_q;
      release_d = sync2_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      stable_q  <= 1'b1;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level         = stable_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

endmodule

// File: rtl/pushbutton_conditioner.sv
// rtl/pushbutton_conditioner.sv - debounced pushbutton levels, edge pulses and a valid/ready event stream
module pushbutton_conditioner
  import pushbutton_pkg::*;
#(
  parameter  int NUM_BUTTONS     = DEFAULT_NUM_BUTTONS,
  parameter  int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  localparam int IDX_W           = idx_width(NUM_BUTTONS)
) (
  input  logic                   clk_clk,
  input  logic                   reset_reset_n,
  input  logic [NUM_BUTTONS-1:0] key_n_in,
  output logic [NUM_BUTTONS-1:0] pushbutton_export,
  output logic [NUM_BUTTONS-1:0] press_pulse,
  output logic [NUM_BUTTONS-1:0] release_pulse,
  output logic                   event_valid,
  input  logic                   event_ready,
  output logic [IDX_W:0]         event_data,
  output logic                   overflow,
  input  logic                   overflow_clr
);

  localparam int EV_IS_RELEASE = ev_is_release_bit(IDX_W);

  logic [NUM_BUTTONS-1:0] press_w, release_w;

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_chan
    button_debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk          (clk_clk),
      .reset_n      (reset_reset_n),
      .key_n        (key_n_in[g]),
      .level        (pushbutton_export[g]),
      .press_pulse  (press_w[g]),
      .release_pulse(release_w[g])
    );
  end

  assign press_pulse   = press_w;
  assign release_pulse = release_w;

  logic [NUM_BUTTONS-1:0] pend_press_q, pend_press_d;
  logic [NUM_BUTTONS-1:0] pend_release_q, pend_release_d;
  logic                   event_valid_q, event_valid_d;
  logic [IDX_W:0]         event_data_q, event_data_d;
  logic                   overflow_q, overflow_d;

  logic [NUM_BUTTONS-1:0] cand_press, cand_release;
  logic [NUM_BUTTONS-1:0] take_press, take_release;
  logic                   found, load, new_overflow;
  logic [IDX_W:0]         pick;

  always_comb begin
    // Fresh commits are eligible in the same cycle as the already-pending events.
    cand_press   = pend_press_q | press_w;
    cand_release = pend_release_q | release_w;
    load         = !event_valid_q || event_ready;
    take_press   = '0;
    take_release = '0;
    found        = 1'b0;
    pick         = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (!found && cand_press[i]) begin
        found         = 1'b1;
        take_press[i] = load;
        pick          = {1'b0, IDX_W'(i)};
      end else if (!found && cand_release[i]) begin
        found                = 1'b1;
        take_release[i]      = load;
        pick                 = {1'b0, IDX_W'(i)};
        pick[EV_IS_RELEASE]  = 1'b1;
      end
    end

    // A commit onto a bit being popped re-arms it; onto an idle set bit it merges.
    pend_press_d   = (cand_press & ~take_press) | (pend_press_q & press_w);
    pend_release_d = (cand_release & ~take_release) | (pend_release_q & release_w);
    new_overflow   = |((pend_press_q & press_w & ~take_press) |
                       (pend_release_q & release_w & ~take_release));

    event_valid_d = event_valid_q;
    event_data_d  = event_data_q;
    if (load) begin
      event_valid_d = found;
      if (found) event_data_d = pick;
    end

    overflow_d = overflow_q;
    if (overflow_clr) overflow_d = 1'b0;
    if (new_overflow) overflow_d = 1'b1;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pend_press_q   <= '0;
      pend_release_q <= '0;
      event_valid_q  <= 1'b0;
      event_data_q   <= '0;
      overflow_q     <= 1'b0;
    end else begin
      pend_press_q   <= pend_press_d;
      pend_release_q <= pend_release_d;
      event_valid_q  <= event_valid_d;
      event_data_q   <= event_data_d;
      overflow_q     <= overflow_d;
    end
  end

  assign event_valid = event_valid_q;
  assign event_data  = event_data_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_pushbutton_conditioner.sv
// tb/tb_pushbutton_conditioner.sv - scoreboard bench for pushbutton_conditioner
module tb_pushbutton_conditioner;

  localparam int NB = 4;
  localparam int DC = 8;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NB-1:0] key_n;
  logic          ready;
  logic          ovf_clr;
  logic [NB-1:0] export_w, press_w, release_w;
  logic          ev_valid;
  logic [IW:0]   ev_data;
  logic          ovf;

  always #5 clk = ~clk;

  pushbutton_conditioner #(
    .NUM_BUTTONS    (NB),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk_clk          (clk),
    .reset_reset_n    (rst_n),
    .key_n_in         (key_n),
    .pushbutton_export(export_w),
    .press_pulse      (press_w),
    .release_pulse    (release_w),
    .event_valid      (ev_valid),
    .event_ready      (ready),
    .event_data       (ev_data),
    .overflow         (ovf),
    .overflow_clr     (ovf_clr)
  );

  int          checks = 0;
  int          errors = 0;
  logic [IW:0] exp_q[$];
  bit          push_en = 1'b1;

  // Reference: a key's level flips once DC consecutive synchronised samples disagree with it.
  bit [NB-1:0] d1, d2, lvl, mp, mr, runv;
  int          run[NB];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic model_tick();
    bit samp;
    if (!rst_n) begin
      d1 = '1; d2 = '1; lvl = '1; runv = '1; mp = '0; mr = '0;
      foreach (run[i]) run[i] = 0;
      exp_q.delete();
    end else begin
      mp = '0;
      mr = '0;
      for (int i = 0; i < NB; i++) begin
        samp = d2[i];
        if (samp == runv[i]) run[i]++;
        else begin
          runv[i] = samp;
          run[i]  = 1;
        end
        if (samp != lvl[i] && run[i] >= DC) begin
          lvl[i] = samp;
          if (samp) mr[i] = 1'b1;
          else      mp[i] = 1'b1;
        end
      end
      if (push_en) begin
        for (int i = 0; i < NB; i++) begin
          logic [IW-1:0] ix;
          ix = IW'(i);
          if (mp[i]) exp_q.push_back({1'b0, ix});
          if (mr[i]) exp_q.push_back({1'b1, ix});
        end
      end
      d2 = d1;
      d1 = key_n;
    end
  endtask

  task automatic monitor_tick();
    int hit;
    if (rst_n) begin
      chk("export", 32'(export_w), 32'(lvl));
      chk("press_pulse", 32'(press_w), 32'(mp));
      chk("release_pulse", 32'(release_w), 32'(mr));
      if (ev_valid && ready) begin
        hit = -1;
        foreach (exp_q[j]) if (hit < 0 && exp_q[j] == ev_data) hit = j;
        checks++;
        if (hit < 0) begin
          errors++;
          $display("FAIL event_unexpected actual=%0h expected_queue_size=%0d t=%0t",
                   ev_data, exp_q.size(), $time);
        end else begin
          exp_q.delete(hit);
        end
      end
    end
  endtask

  task automatic run_tests();
    int hold[NB];
    int np, nr;

    // Reset with keys held down
    steps(3);
    chk("rst_export", 32'(export_w), 32'hF);
    chk("rst_press", 32'(press_w), 0);
    chk("rst_release", 32'(release_w), 0);
    chk("rst_valid", 32'(ev_valid), 0);
    chk("rst_data", 32'(ev_data), 0);
    chk("rst_ovf", 32'(ovf), 0);
    key_n = '1;
    rst_n = 1'b1;
    steps(4);

    // Clean press on key 2
    key_n[2] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 9) chk("clean_before", 32'(export_w[2]), 1);
      if (k == 10) begin
        chk("clean_after", 32'(export_w[2]), 0);
        chk("clean_pulse", 32'(press_w[2]), 1);
      end
    end
    step();
    chk("clean_pulse_gone", 32'(press_w[2]), 0);
    chk("clean_valid", 32'(ev_valid), 1);
    chk("clean_data", 32'(ev_data), 32'b0_10);
    key_n[2] = 1'b1;
    steps(16);

    // Bounce on key 1
    np = 0; nr = 0;
    for (int s = 0; s < 10; s++) begin
      key_n[1] = (s % 2 == 0) ? 1'b0 : 1'b1;
      for (int k = 0; k < 3; k++) begin
        step();
        np += int'(press_w[1]);
        nr += int'(release_w[1]);
      end
    end
    key_n[1] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      np += int'(press_w[1]);
      nr += int'(release_w[1]);
      if (k == 9)  chk("bounce_before", 32'(export_w[1]), 1);
      if (k == 10) chk("bounce_after", 32'(export_w[1]), 0);
    end
    chk("bounce_press_count", 32'(np), 1);
    chk("bounce_release_count", 32'(nr), 0);
    key_n[1] = 1'b1;
    steps(16);

    // Glitch boundary on key 0: 7 low cycles dropped
    np = 0;
    key_n[0] = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 7) key_n[0] = 1'b1;
      np += int'(press_w[0]) + int'(release_w[0]);
    end
    chk("glitch7_pulses", 32'(np), 0);
    chk("glitch7_level", 32'(export_w[0]), 1);
    key_n[0] = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      step();
      if (k == 8)  key_n[0] = 1'b1;
      if (k == 9)  chk("glitch8_before", 32'(export_w[0]), 1);
      if (k == 10) chk("glitch8_press", 32'(export_w[0]), 0);
      if (k == 17) chk("glitch8_hold", 32'(export_w[0]), 0);
      if (k == 18) begin
        chk("glitch8_release", 32'(export_w[0]), 1);
        chk("glitch8_rel_pulse", 32'(release_w[0]), 1);
      end
    end

    // Arbitration: keys 0 and 3 together with the consumer stalled
    ready = 1'b0;
    key_n[0] = 1'b0;
    key_n[3] = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k >= 11 && k <= 14) begin
        chk("arb_valid", 32'(ev_valid), 1);
        chk("arb_hold", 32'(ev_data), 32'b0_00);
      end
      if (k == 14) ready = 1'b1;
      if (k == 15) begin
        chk("arb_second_valid", 32'(ev_valid), 1);
        chk("arb_second", 32'(ev_data), 32'b0_11);
      end
      if (k == 16) chk("arb_empty", 32'(ev_valid), 0);
    end
    key_n = '1;
    steps(16);

    // Overflow: two press/release pairs on key 1 with the consumer stalled
    push_en = 1'b0;
    ready   = 1'b0;
    for (int r = 0; r < 4; r++) begin
      key_n[1] = r[0];
      steps(12);
    end
    chk("ovf_set", 32'(ovf), 1);
    exp_q.push_back(3'b0_01);
    exp_q.push_back(3'b0_01);
    exp_q.push_back(3'b1_01);
    ready = 1'b1;
    steps(5);
    chk("ovf_drained", 32'(ev_valid), 0);
    chk("ovf_sticky", 32'(ovf), 1);
    chk("ovf_queue", 32'(exp_q.size()), 0);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_clr", 32'(ovf), 0);
    push_en = 1'b1;

    // Reset with an event pending and another key mid-debounce
    ready    = 1'b0;
    key_n[2] = 1'b0;
    steps(12);
    chk("pre_rst_valid", 32'(ev_valid), 1);
    key_n[3] = 1'b0;
    steps(4);
    rst_n = 1'b0;
    key_n = '1;
    steps(3);
    chk("mid_rst_export", 32'(export_w), 32'hF);
    chk("mid_rst_valid", 32'(ev_valid), 0);
    rst_n = 1'b1;
    ready = 1'b1;
    np = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      np += int'(ev_valid) + int'(|press_w) + int'(|release_w);
    end
    chk("post_rst_quiet", 32'(np), 0);

    // Randomised keys with a mostly-ready consumer
    foreach (hold[i]) hold[i] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NB; i++) begin
        if (hold[i] == 0) begin
          key_n[i] = 1'($urandom % 2);
          hold[i]  = int'($urandom_range(1, 14));
        end else begin
          hold[i]--;
        end
      end
      if (!ready) ready = 1'b1;
      else        ready = ($urandom % 4) != 0;
      step();
    end
    key_n = '1;
    ready = 1'b1;
    steps(40);
    chk("rand_queue_empty", 32'(exp_q.size()), 0);
    chk("rand_no_ovf", 32'(ovf), 0);
    chk("rand_idle", 32'(ev_valid), 0);
  endtask

  initial begin
    rst_n   = 1'b0;
    key_n   = '0;
    ready   = 1'b1;
    ovf_clr = 1'b0;
    fork
      forever begin
        @(posedge clk);
        model_tick();
      end
      forever begin
        @(negedge clk);
        monitor_tick();
      end
      run_tests();
    join_any
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
